md_sched: RTL

Multi-cycle multiply/divide scheduler for the five-stage pipeline. It accepts one mult/div-family operation from the E stage, holds the unit busy for a fixed number of cycles, and commits results to HI/LO. It also produces the stall request that freezes PC/D while a mult/div-family instruction in D must wait. It sits beside the ALU in E, and its stall output is ORed into the hazard controller's stallpc/stalld.

---
 rtl/md_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// ============================================================================
// Module   : md_sched
// Brief    : Multi-cycle multiply/divide scheduler with HI/LO commit and the
//            PC/D stall request. Define MD_SCHED_MADD_EN to enable the
//            MADD/MADDU/MSUB/MSUBU accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MD_SCHED_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;
`endif

    logic [1:0]         r_state_q, w_state_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
    logic [3:0]         r_op_q,    w_op_d;
    logic [31:0]        r_a_q,     w_a_d;
    logic [31:0]        r_b_q,     w_b_d;
    logic [31:0]        r_hi_q,    w_hi_d;
    logic [31:0]        r_lo_q,    w_lo_d;

    logic        w_mul_op;
    logic        w_div_op;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_mul_res;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

`ifdef MD_SCHED_MADD_EN
    assign w_mul_op = (op == c_op_mult) || (op == c_op_multu) ||
                      ((op >= c_op_madd) && (op <= c_op_msubu));
`else
    assign w_mul_op = (op == c_op_mult) || (op == c_op_multu);
`endif
    assign w_div_op = (op == c_op_div) || (op == c_op_divu);

    assign busy     = (r_state_q != c_st_idle);
    assign stall_md = md_use_D & (busy | (start & (w_mul_op | w_div_op)));
    assign hi       = r_hi_q;
    assign lo       = r_lo_q;

    // 64-bit truncated products of sign/zero-extended operands give exact results
    assign w_prod_s = {{32{r_a_q[31]}}, r_a_q} * {{32{r_b_q[31]}}, r_b_q};
    assign w_prod_u = {32'd0, r_a_q} * {32'd0, r_b_q};

    always_comb begin
        w_mul_res = w_prod_u;
        case (r_op_q)
            c_op_mult:  w_mul_res = w_prod_s;
`ifdef MD_SCHED_MADD_EN
            c_op_madd:  w_mul_res = {r_hi_q, r_lo_q} + w_prod_s;
            c_op_maddu: w_mul_res = {r_hi_q, r_lo_q} + w_prod_u;
            c_op_msub:  w_mul_res = {r_hi_q, r_lo_q} - w_prod_s;
            c_op_msubu: w_mul_res = {r_hi_q, r_lo_q} - w_prod_u;
`endif
            default:    w_mul_res = w_prod_u;
        endcase
    end

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0
    assign w_a_neg = (r_op_q == c_op_div) & r_a_q[31];
    assign w_b_neg = (r_op_q == c_op_div) & r_b_q[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_a_q) : r_a_q;
    assign w_b_mag = w_b_neg ? (32'd0 - r_b_q) : r_b_q;
    assign w_den   = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_op_d    = r_op_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_hi_d    = r_hi_q;
        w_lo_d    = r_lo_q;
        case (r_state_q)
            c_st_idle: begin
                if (start) begin
                    if (w_mul_op) begin
                        w_state_d = c_st_mul;
                        w_cnt_d   = c_mult_cnt;
                        w_op_d    = op;
                        w_a_d     = rs_val;
                        w_b_d     = rt_val;
                    end else if (w_div_op) begin
                        w_state_d = c_st_div;
                        w_cnt_d   = c_div_cnt;
                        w_op_d    = op;
                        w_a_d     = rs_val;
                        w_b_d     = rt_val;
                    end else if (op == c_op_mthi) begin
                        w_hi_d = rs_val;
                    end else if (op == c_op_mtlo) begin
                        w_lo_d = rs_val;
                    end
                end
            end
            default: begin
                if (r_cnt_q == c_cnt_one) begin
                    w_state_d = c_st_idle;
                    w_cnt_d   = '0;
                    if (r_state_q == c_st_mul) begin
                        w_hi_d = w_mul_res[63:32];
                        w_lo_d = w_mul_res[31:0];
                    end else if (r_b_q != 32'd0) begin
                        w_hi_d = w_rem;
                        w_lo_d = w_quot;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - c_cnt_one;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_st_idle;
            r_cnt_q   <= '0;
            r_op_q    <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_hi_q    <= '0;
            r_lo_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_op_q    <= w_op_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_hi_q    <= w_hi_d;
            r_lo_q    <= w_lo_d;
        end
    end

endmodule

`default_nettype wire
